// File: rtl/i2c_tx_fifo.sv
// -----------------------------------------------------------------------------
// i2c_tx_fifo
//
// Synchronous byte FIFO between the host and the I2C master controller. The
// host pushes bytes to be transmitted after the address/RW phase. The
// controller pops one byte per data phase through its read / data_in /
// empty_tx interface.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   write        host push request (accepted when !full)
//   wdata        host write data
//   full         FIFO holds 2^ADDR_WIDTH words
//   almost_full  usedw >= AF_LEVEL
//   read         controller pop request (accepted when !empty_tx)
//   data_in      popped word, valid one cycle after an accepted read
//   empty_tx     FIFO holds 0 words
//   usedw        current word count, 0..2^ADDR_WIDTH
//
// Optional build macro I2C_TX_FIFO_ERR_FLAGS_EN adds:
//   err_clr      clears the sticky error flags (a same-edge set event wins)
//   overflow     sticky: a write was seen while full
//   underflow    sticky: a read was seen while empty
//
// Every output comes straight from a register, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module i2c_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  empty_tx,
  output logic [ADDR_WIDTH:0]   usedw
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;

  logic push_ok;
  logic pop_ok;

  // Acceptance uses the registered flags. A push and a pop on an empty FIFO
  // therefore only accept the push. On a full FIFO they only accept the pop.
  assign push_ok = write && !full_q;
  assign pop_ok  = read  && !empty_q;

  // NOTE: always_comb assigns every _d signal a default first. No path can
  // then leave a signal unassigned, and no latch is inferred.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    data_in_d = data_in_q;

    if (push_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      // A word written on this same edge is not yet in mem, so it cannot be
      // read in the same cycle.
      data_in_d = mem[rptr_q];
      rptr_d    = rptr_q + PTR_ONE;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The flags look at the next count, so they change on the same edge as usedw.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    af_d    = (count_d >= CNT_AF);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, whatever order the processes run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      data_in_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      data_in_q <= data_in_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      af_q      <= af_d;
    end
  end

  // NOTE: the storage array is left out of reset on purpose. It can then map
  // onto RAM. Stale contents are harmless because the pointers and count
  // reset, and no word is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= wdata;
    end
  end

  assign full        = full_q;
  assign almost_full = af_q;
  assign empty_tx    = empty_q;
  assign usedw       = count_q;
  assign data_in     = data_in_q;

`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky flags. A set event on the same edge as err_clr takes priority, so
  // a clear can never hide an error that is happening right now.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (write && full_q) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end
    if (read && empty_q) begin
      unf_d = 1'b1;
    end else if (err_clr) begin
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2c_tx_fifo
//
// Self-checking bench for i2c_tx_fifo. A queue-based reference model tracks the
// stored words, the last popped word and (when I2C_TX_FIFO_ERR_FLAGS_EN is
// defined) the sticky error flags. After every clock step all outputs are
// compared with the model.
// -----------------------------------------------------------------------------
module tb_i2c_tx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic          clk;
  logic          reset;
  logic          write;
  logic [DW-1:0] wdata;
  logic          full;
  logic          almost_full;
  logic          read;
  logic [DW-1:0] data_in;
  logic          empty_tx;
  logic [AW:0]   usedw;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  logic          err_clr;
  logic          overflow;
  logic          underflow;
  logic          m_ovf;
  logic          m_unf;
`endif

  i2c_tx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .wdata       (wdata),
    .full        (full),
    .almost_full (almost_full),
    .read        (read),
    .data_in     (data_in),
    .empty_tx    (empty_tx),
    .usedw       (usedw)
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    ,
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_data;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("usedw",       16'(usedw),       16'(m_q.size()));
    check("empty_tx",    16'(empty_tx),    16'(m_q.size() == 0));
    check("full",        16'(full),        16'(m_q.size() == DEPTH));
    check("almost_full", 16'(almost_full), 16'(m_q.size() >= AFL));
    check("data_in",     16'(data_in),     16'(m_data));
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    check("overflow",    16'(overflow),    16'(m_ovf));
    check("underflow",   16'(underflow),   16'(m_unf));
`endif
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data = '0;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
  endtask

  // One clock step. Inputs are applied 1 ns after an edge. The model is
  // advanced and the outputs are compared 1 ns after the next edge.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] wd,
                      input logic clr);
    bit was_full;
    bit was_empty;
    write = wr;
    read  = rd;
    wdata = wd;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    err_clr = clr;
`endif
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    @(posedge clk);
    #1;
    if (rd && !was_empty) m_data = m_q.pop_front();
    if (wr && !was_full)  m_q.push_back(wd);
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    if (wr && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && was_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
`else
    if (clr) m_data = m_data;  // err_clr has no effect without the feature
`endif
    write = 1'b0;
    read  = 1'b0;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    check_all();
  endtask

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'h7E;

    write = 1'b0;
    read  = 1'b0;
    wdata = '0;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    model_reset();

    // Reset state.
    phase = "reset";
    reset = 1'b0;
    #12;
    check_all();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Three pushes, then three pops.
    phase = "basic";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, seq[i], 1'b0);
    check("usedw3", 16'(usedw), 16'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      check("pop_val", 16'(data_in), 16'(seq[i]));
    end
    check("empty_after", 16'(empty_tx), 16'd1);

    // Fill to full, overflow attempt, drain in order.
    phase = "fill";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("full17", 16'(usedw), 16'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      check("drain_val", 16'(data_in), 16'(i));
    end

    // Steady state: simultaneous push/pop at usedw=5, which also wraps the pointers.
    phase = "stream";
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int n = 0; n < 40; n++) step(1'b1, 1'b1, 8'(8'h10 + n), 1'b0);
    check("stream_usedw", 16'(usedw), 16'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("stream_last", 16'(data_in), 16'h10 + 16'd39);

    // Simultaneous push/pop at the empty and full boundaries.
    phase = "boundary";
    step(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    check("full_pushpop", 16'(usedw), 16'd15);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Underflow and the err_clr priority rules.
    phase = "underflow";
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset between edges.
    phase = "async_reset";
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h99, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("after_reset", 16'(data_in), 16'h99);

    // Randomized traffic.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_tx_fifo.md
Name: i2c_tx_fifo

Overview:
Synchronous byte FIFO that buffers transmit data from the host side and feeds the I2C master controller's `read` / `data_in` / `empty_tx` interface.
- The host writes bytes to be sent after the address/RW phase.
- The controller pops one byte per data phase.
- Single clock domain (system clock, 50 MHz); sits directly upstream of the master controller.

Parameters:
- DATA_WIDTH, 8, width of each stored word (I2C byte).
- ADDR_WIDTH, 4, address bits; depth = 2^ADDR_WIDTH = 16 words.
- AF_LEVEL, 12, `almost_full` asserts when `usedw` >= AF_LEVEL.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- write  input  1  host push request.
- wdata  input  DATA_WIDTH  host write data.
- full  output  1  FIFO holds 2^ADDR_WIDTH words.
- almost_full  output  1  `usedw` >= AF_LEVEL.
- read  input  1  pop request from master controller.
- data_in  output  DATA_WIDTH  popped word, to the controller's `data_in`.
- empty_tx  output  1  FIFO holds 0 words, to the controller's `empty_tx`.
- usedw  output  ADDR_WIDTH+1  current word count, 0..2^ADDR_WIDTH.

Behaviour:
- Reset (`reset`=0, async, takes effect immediately regardless of clk):
  - write/read pointers and count = 0.
  - empty_tx=1, full=0, almost_full=0, usedw=0, data_in=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; first push after release is stored at address 0.
- Push accepted = `write` && !full (registered full).
  - wdata stored at wptr; wptr increments modulo 2^ADDR_WIDTH.
  - A push while full is ignored: memory, pointers and count unchanged.
- Pop accepted = `read` && !empty_tx (registered empty_tx).
  - data_in loads mem[rptr] on that clock edge, so it is valid exactly one cycle after `read` is sampled.
  - rptr increments modulo 2^ADDR_WIDTH.
  - data_in holds its value until the next accepted pop.
  - A pop while empty is ignored: data_in, pointers and count unchanged.
- Count update per edge: +1 if only push accepted; -1 if only pop accepted; unchanged if both or neither.
- Simultaneous push and pop:
  - When empty: pop rejected, push accepted; count 0 -> 1; data_in unchanged.
  - When full: push rejected, pop accepted; count 2^ADDR_WIDTH -> 2^ADDR_WIDTH-1.
  - Otherwise both accepted, count unchanged. Data written this cycle is never readable in the same cycle.
- Flags are registered, computed from the next count, and updated on the same edge as the count:
  - empty_tx = (count==0).
  - full = (count==2^ADDR_WIDTH).
  - almost_full = (count>=AF_LEVEL).
  - usedw = count.
- Pointer wrap-around: after 2^ADDR_WIDTH pushes and pops, pointers return to 0 and FIFO order is preserved.
- No combinational path from any input to any output.

Optional Feature:
- Macro: I2C_TX_FIFO_ERR_FLAGS_EN.
- When defined, three extra ports are added:
  - err_clr (input, 1): error clear.
  - overflow (output, 1): sets on a clock edge where `write`=1 and full=1.
  - underflow (output, 1): sets on a clock edge where `read`=1 and empty_tx=1.
- overflow and underflow are sticky, reset to 0, and clear on an edge where err_clr=1.
- A set event on the same edge as err_clr=1 wins: the flag stays 1.
- When undefined: ports absent; rejected pushes/pops are silently ignored as above.

Test Plan:
- Reset, then push 0xA5, 0x3C, 0x7E on consecutive cycles -> usedw=3, empty_tx=0. Pop 3 times -> data_in = 0xA5, 0x3C, 0x7E each one cycle after `read`; empty_tx=1 and usedw=0 after the third pop.
- Push 16 words 0x00..0x0F -> almost_full=1 after 12th push, full=1 after 16th. 17th push of 0xFF ignored (overflow=1 if macro on). Pop 16 -> 0x00..0x0F in order.
- Push and pop simultaneously for 40 cycles at usedw=5, data 0x10+n -> usedw stays 5, data_in sequence in order, pointers wrap with no loss.
- Simultaneous push 0x55 and pop while empty -> usedw=1, data_in unchanged. Simultaneous push 0x66 and pop while full -> usedw=15, 0x66 not stored.
- Pop while empty -> data_in and usedw unchanged (underflow=1 if macro on). Assert err_clr -> flag 0. Assert err_clr together with another pop-while-empty -> flag stays 1.
- Load 6 words, assert reset low mid-cycle between edges -> empty_tx=1, usedw=0, data_in=0 immediately. After release, push 0x99 and pop -> data_in=0x99.
